// File: rtl/cr_xp10_decomp_ib_tlv_rx.sv
// Inbound TLV receiver: checks each TLV's framing against its header length and steers
// compressed-frame DATA TLVs to the data stream and everything else to the pass-through stream.
module cr_xp10_decomp_ib_tlv_rx #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned LEN_W     = 16,
    parameter logic [7:0]  DATA_TYPE = 8'h05
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              ib_tvalid_i,
    output logic              ib_tready_o,
    input  logic [DATA_W-1:0] ib_tdata_i,
    input  logic              ib_sot_i,
    input  logic              ib_eot_i,

    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic [DATA_W-1:0] data_tdata_o,
    output logic              data_sot_o,
    output logic              data_eot_o,

    output logic              pt_valid_o,
    input  logic              pt_ready_i,
    output logic [DATA_W-1:0] pt_tdata_o,
    output logic              pt_sot_o,
    output logic              pt_eot_o,

    output logic              err_valid_o,
    output logic [2:0]        err_code_o,
    output logic [31:0]       tlv_cnt_o
);

    typedef enum logic [1:0] {StIdle, StBody, StDrain} state_e;

    localparam logic [2:0] ErrNoSot    = 3'd1;
    localparam logic [2:0] ErrEarlyEot = 3'd2;
    localparam logic [2:0] ErrNoEot    = 3'd3;
    localparam logic [2:0] ErrZeroLen  = 3'd4;

    state_e             state_q, state_d;
    logic               sel_q, sel_d;
    logic [LEN_W-1:0]   rem_q, rem_d;

    logic               sel;
    logic               ib_ready;
    logic               accept;
    logic [LEN_W-1:0]   hdr_len;
    logic [LEN_W-1:0]   hdr_rem;
    logic               data_free;
    logic               pt_free;

    logic               fwd;
    logic               fwd_sot;
    logic               fwd_eot;
    logic               err_d;
    logic [2:0]         err_code_d;

    logic               data_valid_q;
    logic [DATA_W-1:0]  data_tdata_q;
    logic               data_sot_q;
    logic               data_eot_q;
    logic               pt_valid_q;
    logic [DATA_W-1:0]  pt_tdata_q;
    logic               pt_sot_q;
    logic               pt_eot_q;
    logic               err_valid_q;
    logic [2:0]         err_code_q;
    logic [31:0]        tlv_cnt_q;

    // A zero length header is handled as a one-word TLV.
    assign hdr_len = ib_tdata_i[8 +: LEN_W];
    assign hdr_rem = (hdr_len == '0) ? '0 : hdr_len - LEN_W'(1);

    // Destination is decoded from the live header in IDLE, then held for the body.
    assign sel       = (state_q == StIdle) ? (ib_tdata_i[7:0] == DATA_TYPE) : sel_q;
    assign data_free = !data_valid_q || data_ready_i;
    assign pt_free   = !pt_valid_q || pt_ready_i;
    assign accept    = ib_tvalid_i && ib_ready;

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            rem_q   <= rem_d;
        end
    end

    // FSM: next state, forwarding decision and error detection
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rem_d      = rem_q;
        fwd        = 1'b0;
        fwd_sot    = 1'b0;
        fwd_eot    = 1'b0;
        err_d      = 1'b0;
        err_code_d = '0;
        if (accept) begin
            case (state_q)
                StIdle: begin
                    if (ib_sot_i) begin
                        sel_d   = sel;
                        rem_d   = hdr_rem;
                        fwd     = 1'b1;
                        fwd_sot = 1'b1;
                        fwd_eot = ib_eot_i;
                        if (hdr_rem == '0) begin
                            if (!ib_eot_i) begin
                                fwd_eot    = 1'b1;
                                state_d    = StDrain;
                                err_d      = 1'b1;
                                err_code_d = ErrNoEot;
                            end
                        end else if (ib_eot_i) begin
                            err_d      = 1'b1;
                            err_code_d = ErrEarlyEot;
                        end else begin
                            state_d = StBody;
                        end
                        // Zero length only reports when no lower code fired.
                        if (hdr_len == '0 && !err_d) begin
                            err_d      = 1'b1;
                            err_code_d = ErrZeroLen;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ErrNoSot;
                    end
                end
                StBody: begin
                    fwd     = 1'b1;
                    fwd_eot = ib_eot_i;
                    rem_d   = (rem_q == '0) ? '0 : rem_q - LEN_W'(1);
                    if (rem_q <= LEN_W'(1)) begin
                        state_d = (ib_eot_i) ? StIdle : StDrain;
                        if (!ib_eot_i) begin
                            fwd_eot    = 1'b1;
                            err_d      = 1'b1;
                            err_code_d = ErrNoEot;
                        end
                    end else if (ib_eot_i) begin
                        state_d    = StIdle;
                        err_d      = 1'b1;
                        err_code_d = ErrEarlyEot;
                    end
                end
                StDrain: begin
                    if (ib_eot_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        ib_ready = 1'b0;
        if (!rst_i) begin
            case (state_q)
                StIdle:  ib_ready = !ib_sot_i || (sel ? data_free : pt_free);
                StBody:  ib_ready = sel ? data_free : pt_free;
                StDrain: ib_ready = 1'b1;
                default: ib_ready = 1'b0;
            endcase
        end
    end

    // Output stage control, error pulse and TLV counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_valid_q <= 1'b0;
            pt_valid_q   <= 1'b0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            tlv_cnt_q    <= '0;
        end else begin
            if (fwd && sel) begin
                data_valid_q <= 1'b1;
            end else if (data_ready_i) begin
                data_valid_q <= 1'b0;
            end
            if (fwd && !sel) begin
                pt_valid_q <= 1'b1;
            end else if (pt_ready_i) begin
                pt_valid_q <= 1'b0;
            end
            err_valid_q <= err_d;
            err_code_q  <= err_code_d;
            if (fwd && fwd_eot) begin
                tlv_cnt_q <= tlv_cnt_q + 32'd1;
            end
        end
    end

    // Payload registers only load on forward, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (fwd && sel) begin
            data_tdata_q <= ib_tdata_i;
            data_sot_q   <= fwd_sot;
            data_eot_q   <= fwd_eot;
        end
        if (fwd && !sel) begin
            pt_tdata_q <= ib_tdata_i;
            pt_sot_q   <= fwd_sot;
            pt_eot_q   <= fwd_eot;
        end
    end

    assign ib_tready_o  = ib_ready;
    assign data_valid_o = data_valid_q;
    assign data_tdata_o = data_tdata_q;
    assign data_sot_o   = data_sot_q;
    assign data_eot_o   = data_eot_q;
    assign pt_valid_o   = pt_valid_q;
    assign pt_tdata_o   = pt_tdata_q;
    assign pt_sot_o     = pt_sot_q;
    assign pt_eot_o     = pt_eot_q;
    assign err_valid_o  = err_valid_q;
    assign err_code_o   = err_code_q;
    assign tlv_cnt_o    = tlv_cnt_q;

endmodule

// File: tb/tb_cr_xp10_decomp_ib_tlv_rx.sv
// Self-checking bench for cr_xp10_decomp_ib_tlv_rx: table-driven TLV words with a
// scoreboard of expected output beats and error codes.
module tb_cr_xp10_decomp_ib_tlv_rx;

    localparam int DN = 0;  // dropped
    localparam int DD = 1;  // data stream
    localparam int DP = 2;  // pass-through stream

    logic        clk = 1'b0;
    logic        rst;
    logic        ib_tvalid, ib_tready, ib_sot, ib_eot;
    logic [63:0] ib_tdata;
    logic        data_valid, data_ready, data_sot, data_eot;
    logic [63:0] data_tdata;
    logic        pt_valid, pt_ready, pt_sot, pt_eot;
    logic [63:0] pt_tdata;
    logic        err_valid;
    logic [2:0]  err_code;
    logic [31:0] tlv_cnt;

    always #5 clk = ~clk;

    cr_xp10_decomp_ib_tlv_rx dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ib_tvalid_i  (ib_tvalid),
        .ib_tready_o  (ib_tready),
        .ib_tdata_i   (ib_tdata),
        .ib_sot_i     (ib_sot),
        .ib_eot_i     (ib_eot),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .data_tdata_o (data_tdata),
        .data_sot_o   (data_sot),
        .data_eot_o   (data_eot),
        .pt_valid_o   (pt_valid),
        .pt_ready_i   (pt_ready),
        .pt_tdata_o   (pt_tdata),
        .pt_sot_o     (pt_sot),
        .pt_eot_o     (pt_eot),
        .err_valid_o  (err_valid),
        .err_code_o   (err_code),
        .tlv_cnt_o    (tlv_cnt)
    );

    typedef struct {
        logic        sot;
        logic        eot;
        logic [63:0] data;
        int          dst;
        logic        xsot;
        logic        xeot;
        int          err;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        sot;
        logic        eot;
    } beat_t;

    beat_t dq[$];
    beat_t pq[$];
    int    eq[$];
    vec_t  tbl[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic e, input logic [63:0] d,
                                input int dst, input logic xs, input logic xe, input int err);
        vec_t v;
        v.sot = s; v.eot = e; v.data = d; v.dst = dst; v.xsot = xs; v.xeot = xe; v.err = err;
        return v;
    endfunction

    function automatic logic [63:0] hdr(input logic [7:0] t, input logic [15:0] l,
                                        input logic [39:0] tag);
        return {tag, l, t};
    endfunction

    // Scoreboard side: a beat is compared on the negedge before the edge that transfers it.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (data_valid && data_ready) begin
                if (dq.size() == 0) check("data_unexpected", 1, 0);
                else begin
                    b = dq.pop_front();
                    check("data_beat", {data_sot, data_eot, data_tdata}, {b.sot, b.eot, b.data});
                end
            end
            if (pt_valid && pt_ready) begin
                if (pq.size() == 0) check("pt_unexpected", 1, 0);
                else begin
                    b = pq.pop_front();
                    check("pt_beat", {pt_sot, pt_eot, pt_tdata}, {b.sot, b.eot, b.data});
                end
            end
            if (err_valid) begin
                if (eq.size() == 0) check("err_unexpected", {1'b1, err_code}, 0);
                else check("err_code", err_code, eq.pop_front());
            end
        end
    end

    task automatic send(input vec_t v, output int waits);
        bit ok;
        ok = 1'b0;
        waits = 0;
        ib_tvalid = 1'b1;
        ib_sot = v.sot;
        ib_eot = v.eot;
        ib_tdata = v.data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ib_tready) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            check("ib_accept_timeout", 0, 1);
            ib_tvalid = 1'b0;
            return;
        end
        if (v.dst == DD) dq.push_back('{v.data, v.xsot, v.xeot});
        if (v.dst == DP) pq.push_back('{v.data, v.xsot, v.xeot});
        if (v.err != 0) eq.push_back(v.err);
        @(posedge clk);
        #1;
        ib_tvalid = 1'b0;
    endtask

    task automatic run_tbl(input bit no_stall);
        int w;
        foreach (tbl[i]) begin
            send(tbl[i], w);
            if (no_stall) check("ib_tready_no_stall", w, 0);
        end
        tbl.delete();
    endtask

    task automatic settle(input int exp_cnt);
        repeat (4) @(posedge clk);
        #1;
        check("data_q_drained", dq.size(), 0);
        check("pt_q_drained", pq.size(), 0);
        check("err_q_drained", eq.size(), 0);
        check("tlv_cnt", tlv_cnt, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [63:0] h;
        rst = 1'b1;
        ib_tvalid = 1'b0;
        ib_sot = 1'b0;
        ib_eot = 1'b0;
        ib_tdata = '0;
        data_ready = 1'b1;
        pt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ib_tready", ib_tready, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_pt_valid", pt_valid, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_tlv_cnt", tlv_cnt, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: data TLV len 4
        tbl.push_back(mk(1, 0, hdr(8'h05, 16'd4, 40'h11), DD, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'hA1, DD, 0, 0, 0));
        tbl.push_back(mk(0, 0, 64'hA2, DD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'hA3, DD, 0, 1, 0));
        run_tbl(1);
        settle(1);

        // 2: pt len 2 then data len 3, back to back
        tbl.push_back(mk(1, 0, hdr(8'h01, 16'd2, 40'h21), DP, 1, 0, 0));
        tbl.push_back(mk(0, 1, 64'hB1, DP, 0, 1, 0));
        tbl.push_back(mk(1, 0, hdr(8'h05, 16'd3, 40'h22), DD, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'hB2, DD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'hB3, DD, 0, 1, 0));
        run_tbl(1);
        settle(3);

        // 3: downstream stall mid-TLV
        h = hdr(8'h05, 16'd4, 40'h31);
        send(mk(1, 0, h, DD, 1, 0, 0), w);
        data_ready = 1'b0;
        ib_tvalid = 1'b1;
        ib_sot = 1'b0;
        ib_eot = 1'b0;
        ib_tdata = 64'hC1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_ib_tready", ib_tready, 0);
            check("stall_data_hold", {data_valid, data_sot, data_tdata}, {1'b1, 1'b1, h});
        end
        @(posedge clk);
        #1;
        data_ready = 1'b1;
        tbl.push_back(mk(0, 0, 64'hC1, DD, 0, 0, 0));
        tbl.push_back(mk(0, 0, 64'hC2, DD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'hC3, DD, 0, 1, 0));
        run_tbl(0);
        settle(4);

        // 4: early eot, then a normal TLV
        tbl.push_back(mk(1, 0, hdr(8'h05, 16'd5, 40'h41), DD, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'hD1, DD, 0, 0, 0));
        tbl.push_back(mk(0, 0, 64'hD2, DD, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'hD3, DD, 0, 1, 2));
        tbl.push_back(mk(1, 1, hdr(8'h01, 16'd1, 40'h42), DP, 1, 1, 0));
        run_tbl(0);
        settle(6);

        // 5: missing eot, forced eot and drain
        tbl.push_back(mk(1, 0, hdr(8'h05, 16'd2, 40'h51), DD, 1, 0, 0));
        tbl.push_back(mk(0, 0, 64'hE1, DD, 0, 1, 3));
        tbl.push_back(mk(0, 0, 64'hE2, DN, 0, 0, 0));
        tbl.push_back(mk(1, 0, 64'hE3, DN, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'hE4, DN, 0, 0, 0));
        tbl.push_back(mk(1, 1, hdr(8'h05, 16'd1, 40'h52), DD, 1, 1, 0));
        run_tbl(0);
        settle(8);

        // 6: no sot, zero length, stray sot, header-only early eot, zero length without eot
        tbl.push_back(mk(0, 0, 64'hF1, DN, 0, 0, 1));
        tbl.push_back(mk(1, 1, hdr(8'h01, 16'd0, 40'h61), DP, 1, 1, 4));
        tbl.push_back(mk(1, 0, hdr(8'h01, 16'd3, 40'h62), DP, 1, 0, 0));
        tbl.push_back(mk(1, 0, 64'hF2, DP, 0, 0, 0));
        tbl.push_back(mk(0, 1, 64'hF3, DP, 0, 1, 0));
        tbl.push_back(mk(1, 1, hdr(8'h05, 16'd3, 40'h63), DD, 1, 1, 2));
        tbl.push_back(mk(1, 0, hdr(8'h05, 16'd0, 40'h64), DD, 1, 1, 3));
        tbl.push_back(mk(0, 1, 64'hF4, DN, 0, 0, 0));
        run_tbl(0);
        settle(12);

        // reset mid-BODY
        send(mk(1, 0, hdr(8'h01, 16'd4, 40'h71), DP, 1, 0, 0), w);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ib_tready", ib_tready, 0);
        @(posedge clk);
        #1;
        check("midrst_pt_valid", pt_valid, 0);
        check("midrst_data_valid", data_valid, 0);
        check("midrst_err_valid", err_valid, 0);
        check("midrst_tlv_cnt", tlv_cnt, 0);
        pq.delete();
        rst = 1'b0;
        tbl.push_back(mk(0, 0, 64'h7A, DN, 0, 0, 1));
        tbl.push_back(mk(1, 1, hdr(8'h05, 16'd1, 40'h72), DD, 1, 1, 0));
        run_tbl(0);
        settle(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
